// File: rtl/serial2parallel_pkg.sv
// Shared definitions for the serial-to-parallel receive path.
//   state_e    : receiver FSM states (HUNT waits for a word start, SHIFT collects bits)
//   FIFO_DEPTH : number of entries in the output FIFO
package serial2parallel_pkg;

  typedef enum logic [0:0] {HUNT, SHIFT} state_e;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/s2p_fifo2.sv
// Two-entry register FIFO with registered outputs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, wdata : write request and data; accepted when not full, or when full with a pop
//   pop         : read request; ignored when empty
//   rdata       : head entry (first in)
//   full, empty : occupancy flags
module s2p_fifo2
  import serial2parallel_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [1:0]       count_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count_q == DEPTH);
    empty   = (count_q == 2'd0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = head_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (empty) head_q <= wdata;
          else       tail_q <= wdata;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_q <= wdata;
          end else begin
            head_q <= tail_q;
            tail_q <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/serial2parallel.sv
// Rebuilds parallel words from an MSB-first serial stream framed by a word-start marker.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   din, din_sof     : serial bit and start-of-word marker (high with the MSB)
//   m_data, m_valid  : head of the 2-entry output FIFO
//   m_ready          : consumer accept; a pop happens when m_valid && m_ready
//   sync_err         : pulse, partial word discarded because of an early din_sof
//   overflow         : pulse, completed word dropped because the FIFO was full
//   drop_cnt         : saturating count of dropped words
module serial2parallel
  import serial2parallel_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_sof,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             sync_err,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic             sync_err_q;
  logic             overflow_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic [WIDTH-1:0] msb_word;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop;

  always_comb begin
    msb_word  = {din, {(WIDTH-1){1'b0}}};
    // Bit 0 of shreg_q is never written, so the LSB can be merged straight from din.
    word      = shreg_q | {{(WIDTH-1){1'b0}}, din};
    word_done = (state_q == SHIFT) && !din_sof && (cnt_q == LAST);
    pop       = m_valid && m_ready;
    push      = word_done;
    drop      = word_done && fifo_full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      shreg_q    <= '0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sync_err_q <= 1'b0;
      overflow_q <= drop;
      if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_q <= drop_cnt_q + 1'b1;

      unique case (state_q)
        HUNT: begin
          if (din_sof) begin
            shreg_q <= msb_word;
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (din_sof) begin
            // Restart on the current bit; the partial word is thrown away.
            sync_err_q <= 1'b1;
            shreg_q    <= msb_word;
            cnt_q      <= CW'(1);
          end else if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= HUNT;
          end else begin
            shreg_q[LAST - cnt_q] <= din;
            cnt_q                 <= cnt_q + 1'b1;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  s2p_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(word),
    .pop  (pop),
    .rdata(m_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign m_valid  = !fifo_empty;
  assign sync_err = sync_err_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_serial2parallel.sv
// Bench for serial2parallel: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the framing rules. A second instance with CNT_W=2 shares
// the stimulus to exercise drop counter saturation.
module tb_serial2parallel;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         din_sof = 1'b0;
  logic         m_ready = 1'b1;

  logic [W-1:0] m_data;
  logic         m_valid;
  logic         sync_err;
  logic         overflow;
  logic [7:0]   drop_cnt;

  logic [W-1:0] m_data2;
  logic         m_valid2;
  logic         sync_err2;
  logic         overflow2;
  logic [1:0]   drop_cnt2;

  serial2parallel #(.WIDTH(W), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_sof (din_sof),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .sync_err(sync_err),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  serial2parallel #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_sof (din_sof),
    .m_data  (m_data2),
    .m_valid (m_valid2),
    .m_ready (m_ready),
    .sync_err(sync_err2),
    .overflow(overflow2),
    .drop_cnt(drop_cnt2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits of the word in progress, expected FIFO contents, expected pulses.
  bit           bits_q[$];
  logic [W-1:0] fifo_q[$];
  bit           in_word = 0;
  bit           exp_se = 0;
  bit           exp_ov = 0;
  int           exp_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_all();
    chk("m_valid", 32'(m_valid), 32'(fifo_q.size() > 0));
    chk("m_valid2", 32'(m_valid2), 32'(fifo_q.size() > 0));
    if (fifo_q.size() > 0) begin
      chk("m_data", 32'(m_data), 32'(fifo_q[0]));
      chk("m_data2", 32'(m_data2), 32'(fifo_q[0]));
    end
    chk("sync_err", 32'(sync_err), 32'(exp_se));
    chk("sync_err2", 32'(sync_err2), 32'(exp_se));
    chk("overflow", 32'(overflow), 32'(exp_ov));
    chk("overflow2", 32'(overflow2), 32'(exp_ov));
    chk("drop_cnt", 32'(drop_cnt), 32'(sat(exp_drop, 255)));
    chk("drop_cnt_sat", 32'(drop_cnt2), 32'(sat(exp_drop, 3)));
  endtask

  task automatic model_edge(input bit d, input bit s);
    bit           do_pop;
    bit           done;
    logic [W-1:0] w;
    do_pop = (fifo_q.size() > 0) && m_ready;
    exp_se = 0;
    exp_ov = 0;
    done   = 0;
    w      = '0;
    if (s) begin
      exp_se = in_word;
      bits_q.delete();
      bits_q.push_back(d);
      in_word = 1;
    end else if (in_word) begin
      bits_q.push_back(d);
      if (bits_q.size() == W) begin
        foreach (bits_q[i]) w = (w << 1) | W'(bits_q[i]);
        done = 1;
        bits_q.delete();
        in_word = 0;
      end
    end
    if (do_pop) void'(fifo_q.pop_front());
    if (done) begin
      if (fifo_q.size() < 2) fifo_q.push_back(w);
      else begin
        exp_ov = 1;
        exp_drop++;
      end
    end
  endtask

  task automatic step(input bit d, input bit s);
    @(negedge clk);
    din     = d;
    din_sof = s;
    @(posedge clk);
    model_edge(d, s);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) step(w[i], i == W - 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    bits_q.delete();
    fifo_q.delete();
    in_word  = 0;
    exp_se   = 0;
    exp_ov   = 0;
    exp_drop = 0;
    din      = 1'b0;
    din_sof  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset
    do_reset();
    idle(2);

    // Single word 1010 with consumer ready
    m_ready = 1'b1;
    send_word(4'hA);
    idle(2);

    // Back-to-back words
    send_word(4'h5);
    send_word(4'hC);
    send_word(4'h3);
    idle(3);

    // Early start marker after two bits
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    send_word(4'h6);
    idle(3);

    // Overflow with consumer stalled, then drain
    m_ready = 1'b0;
    send_word(4'h1);
    send_word(4'h2);
    send_word(4'h3);
    idle(3);
    m_ready = 1'b1;
    idle(4);

    // Drop counter saturation (CNT_W=2 instance)
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_word(W'(i + 7));
    idle(2);
    m_ready = 1'b1;
    idle(4);

    // Reset in the middle of a word
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    send_word(4'h9);
    idle(3);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 5) send_word(W'($urandom));
      else step(1'($urandom), $urandom_range(0, 3) == 0);
    end
    m_ready = 1'b1;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial2parallel.md
Name: serial2parallel

Overview:
- Downstream neighbour of the 4-bit parallel-to-serial stage; rebuilds parallel words from its serial output.
- Consumes the serial bit stream plus a word-start marker. The bit stream arrives MSB first, one bit per clk. The upstream valid pulse serves as the word-start marker and coincides with the MSB.
- Shifts WIDTH bits into a word and pushes completed words into a 2-entry output FIFO with a valid/ready handshake.
- Detects misalignment (start marker arriving mid-word) and output overflow, and reports both.

Parameters:
- WIDTH, 4, bits per word; must be >= 2.
- CNT_W, 8, width of the saturating dropped-word counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- din  input  1  serial data bit, MSB of the word first
- din_sof  input  1  start of word; high in the cycle din carries the MSB
- m_data  output  WIDTH  head-of-FIFO word, MSB = first received bit
- m_valid  output  1  FIFO not empty
- m_ready  input  1  consumer accepts m_data when m_valid && m_ready
- sync_err  output  1  one-cycle pulse: partial word discarded on early din_sof
- overflow  output  1  one-cycle pulse: completed word dropped, FIFO full
- drop_cnt  output  CNT_W  count of dropped words, saturates at all-ones

Behaviour:
- Reset (async assert, sync release): state=HUNT; bit counter=0; shift reg=0; FIFO empty.
- Output reset values: m_data=0, m_valid=0, sync_err=0, overflow=0, drop_cnt=0.
- FSM, 2 states:
  - HUNT: din ignored while din_sof=0. On a sample with din_sof=1: shift_reg[WIDTH-1]<=din, cnt<=1, go to SHIFT.
  - SHIFT: each cycle shifts din in at the next lower bit position and increments cnt.
  - SHIFT, word completes: the sample with cnt==WIDTH-1 and din_sof=0 completes the word and pushes it; then cnt<=0 and state returns to HUNT.
  - SHIFT, early din_sof: din_sof=1 while cnt in 1..WIDTH-1 causes the following, all in that cycle:
    - sync_err pulses for one cycle.
    - The partial word is discarded.
    - The current bit becomes the MSB of a new word (cnt<=1); state stays SHIFT.
    - No push occurs.
- Back-to-back words: din_sof exactly one cycle after the completing bit is the normal case. It is taken in HUNT and gives no sync_err. This gives sustained throughput of 1 word per WIDTH cycles.
- Gaps: idle cycles between words (din_sof=0 in HUNT) are legal and silent.
- Latency: m_valid rises in the cycle after the edge that samples the LSB, when the FIFO was empty. m_data is valid in that same cycle.
- FIFO: 2 entries, registered outputs, first-in first-out.
  - Pop: occurs at the edge where m_valid && m_ready.
  - Push when full: allowed only if a pop occurs in the same cycle.
  - Simultaneous push and pop on one entry: count unchanged, m_data shows the new word.
- Overflow: word completes while the FIFO is full and m_ready=0.
  - The word is dropped; FIFO contents are unchanged.
  - overflow pulses in the next cycle.
  - drop_cnt increments by 1, saturating at 2^CNT_W-1 with no wrap.
- Sticky counter: drop_cnt clears only on reset.
- Pulse alignment: sync_err and overflow are registered pulses, asserted in the cycle after the causing sample. They may be high in the same cycle.
- m_data stability: m_data and m_valid hold stable while m_valid && !m_ready.
- Reset mid-word: the partial word is lost and no output pulses are generated. After release, the block waits in HUNT for the next din_sof.
- Width rules: cnt is clog2(WIDTH) bits wide. drop_cnt uses a saturating compare, not an overflow carry.

Decomposition:
- Shared package: state enum {HUNT, SHIFT}; localparam FIFO_DEPTH=2.
- Sub-module: s2p_fifo2 (2-entry register FIFO with push, pop, full, empty and a same-cycle push+pop rule). It is reused elsewhere in the serial path.
- The FSM, shifter, error pulses and drop counter live in the top module.

Test Plan:
- WIDTH=4, m_ready=1: din 1,0,1,0 with din_sof on the first bit -> m_data=4'hA, with m_valid high exactly one cycle, one cycle after the 4th bit; no error pulses.
- Drive the reference serializer with d=4'h5, 4'hC, 4'h3 back-to-back -> m_data sequence 5,C,3, one word every 4 cycles; sync_err never asserts.
- Bits 1,1 then din_sof with bits 0,1,1,0 -> sync_err pulses once; m_data=4'h6; the partial word is never output.
- m_ready=0, send 3 words 1,2,3 -> FIFO holds 1,2; overflow pulses once; drop_cnt=1. Then m_ready=1 -> outputs 1 then 2 only.
- CNT_W=2, m_ready=0, send 6 words -> drop_cnt goes 1,2,3,3 (saturates); overflow pulses 4 times.
- Assert rst_n low after the 2nd bit of a word -> all outputs 0 immediately. After release, bits without din_sof are ignored until the next din_sof word, which decodes correctly.
